// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: owns the fetch PC and keeps one 64-bit bus read outstanding.
// It feeds a 2-entry instruction FIFO toward decode and drops reads that a redirect has made stale.
`timescale 1ns/1ps
module ysyx_22040759_ifu #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redirect_valid_i,
   input  logic [63:0] redirect_pc_i,
   output logic        if_addr_valid_o,
   output logic [63:0] if_rd_addr_o,
   input  logic        if_data_valid_i,
   input  logic [63:0] if_data_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [63:0] inst_pc_o,
   output logic [31:0] inst_o
);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } entry_t;

   state_e      state_q, state_d;
   logic [63:0] fetch_pc_q, fetch_pc_d;
   logic [63:0] req_pc_q, req_pc_d;
   logic [63:0] rd_addr_q, rd_addr_d;
   logic        addr_valid_q, addr_valid_d;
   entry_t      fifo_q [2];
   entry_t      fifo_d [2];
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [1:0]  count_q, count_d;
   logic        push, pop;
   entry_t      push_entry;

   assign if_addr_valid_o = addr_valid_q;
   assign if_rd_addr_o    = rd_addr_q;
   assign inst_valid_o    = (count_q != 2'd0) && !redirect_valid_i;
   assign inst_pc_o       = fifo_q[rd_ptr_q].pc;
   assign inst_o          = fifo_q[rd_ptr_q].inst;

   // A redirect cancels both the response push and the decode pop of the same cycle.
   assign pop        = inst_valid_o && inst_ready_i;
   assign push       = (state_q == WAIT) && if_data_valid_i && !redirect_valid_i;
   assign push_entry = {req_pc_q, req_pc_q[2] ? if_data_i[63:32] : if_data_i[31:0]};

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      rd_addr_d    = rd_addr_q;
      addr_valid_d = addr_valid_q;

      case (state_q)
         IDLE: begin
            if (!redirect_valid_i && count_q != 2'd2) begin
               addr_valid_d = 1'b1;
               rd_addr_d    = {fetch_pc_q[63:3], 3'b000};
               req_pc_d     = fetch_pc_q;
               fetch_pc_d   = fetch_pc_q + 64'd4;
               state_d      = WAIT;
            end
         end
         WAIT: begin
            if (if_data_valid_i) begin
               addr_valid_d = 1'b0;
               state_d      = IDLE;
            end else if (redirect_valid_i) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (if_data_valid_i) begin
               addr_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (redirect_valid_i) begin
         fetch_pc_d = {redirect_pc_i[63:2], 2'b00};
      end
   end

   always_comb begin
      fifo_d   = fifo_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (redirect_valid_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + 2'(push) - 2'(pop);
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= '0;
         rd_addr_q    <= '0;
         addr_valid_q <= 1'b0;
         // NOTE: the two entries are reset so the decode-facing pc/inst read zero out of reset.
         fifo_q[0]    <= '0;
         fifo_q[1]    <= '0;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         rd_addr_q    <= rd_addr_d;
         addr_valid_q <= addr_valid_d;
         fifo_q       <= fifo_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
// Bench for ysyx_22040759_ifu: a bus responder, directed scenarios, random redirect/backpressure,
// and a negedge monitor comparing the DUT with a queue-based model of the fetch stream.
`timescale 1ns/1ps
module tb_ysyx_22040759_ifu;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid_i = 1'b0;
   logic [63:0] redirect_pc_i = '0;
   logic        if_addr_valid_o;
   logic [63:0] if_rd_addr_o;
   logic        if_data_valid_i = 1'b0;
   logic [63:0] if_data_i = '0;
   logic        inst_valid_o;
   logic        inst_ready_i = 1'b0;
   logic [63:0] inst_pc_o;
   logic [31:0] inst_o;

   always #5 clock = ~clock;

   ysyx_22040759_ifu #(.RESET_PC(RESET_PC)) dut (
      .clock            (clock),
      .reset            (reset),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .if_addr_valid_o  (if_addr_valid_o),
      .if_rd_addr_o     (if_rd_addr_o),
      .if_data_valid_i  (if_data_valid_i),
      .if_data_i        (if_data_i),
      .inst_valid_o     (inst_valid_o),
      .inst_ready_i     (inst_ready_i),
      .inst_pc_o        (inst_pc_o),
      .inst_o           (inst_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory image the responder serves; the reset-fetch doubleword is fixed.
   function automatic logic [63:0] mem_word(input logic [63:0] a);
      logic [63:0] al;
      al = {a[63:3], 3'b000};
      if (al == 64'h0000_0000_8000_0000) return 64'h0000_0013_0010_0093;
      return {al[31:0] ^ 32'h1357_9bdf ^ al[63:32], al[34:3] * 32'h9e37_79b9};
   endfunction

   // Bus responder: answers each request after a random or forced delay.
   int force_delay = -1;
   bit spurious_en = 1'b0;
   int pend = 0;
   int delay = 0;

   always @(posedge clock) begin
      #1;
      if (reset) begin
         if_data_valid_i = 1'b0;
         pend = 0;
      end else if (if_data_valid_i) begin
         if_data_valid_i = 1'b0;
      end else if (pend != 0) begin
         if (delay == 0) begin
            if_data_valid_i = 1'b1;
            if_data_i = mem_word(if_rd_addr_o);
            pend = 0;
         end else begin
            delay--;
         end
      end else if (if_addr_valid_o) begin
         pend = 1;
         delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
      end else if (spurious_en && $urandom_range(0, 9) == 0) begin
         if_data_valid_i = 1'b1;
         if_data_i = {$urandom, $urandom};
      end
   end

   // Reference model: the instruction stream is sequential from the fetch PC, restarts at each
   // redirect target, and anything fetched before a redirect never reaches decode.
   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] m_pc = RESET_PC;
   logic [63:0] m_req = '0;
   logic [63:0] m_addr = '0;
   bit          m_busy = 1'b0;
   bit          m_cancel = 1'b0;
   int          pops = 0;

   always @(negedge clock) begin
      int  cnt;
      bit  exp_valid;
      logic [63:0] w;
      if (reset) begin
         exp_q.delete();
         m_pc = RESET_PC;
         m_busy = 1'b0;
         m_cancel = 1'b0;
         check("rst_addr_valid", if_addr_valid_o, 1'b0);
         check("rst_rd_addr", if_rd_addr_o, 64'd0);
         check("rst_inst_valid", inst_valid_o, 1'b0);
         check("rst_inst_pc", inst_pc_o, 64'd0);
         check("rst_inst", inst_o, 32'd0);
      end else begin
         cnt = exp_q.size();
         exp_valid = (cnt != 0) && !redirect_valid_i;
         check("req_valid", if_addr_valid_o, m_busy);
         if (m_busy) check("req_addr", if_rd_addr_o, m_addr);
         check("inst_valid", inst_valid_o, exp_valid);
         if (exp_valid) begin
            check("inst_pc", inst_pc_o, exp_q[0].pc);
            check("inst", inst_o, exp_q[0].inst);
         end
         // Effects of the coming edge.
         if (exp_valid && inst_ready_i) begin
            void'(exp_q.pop_front());
            pops++;
         end
         if (!m_busy) begin
            if (cnt < 2 && !redirect_valid_i) begin
               m_busy = 1'b1;
               m_cancel = 1'b0;
               m_req = m_pc;
               m_addr = {m_pc[63:3], 3'b000};
               m_pc = m_pc + 64'd4;
            end
         end else if (if_data_valid_i) begin
            m_busy = 1'b0;
            if (!m_cancel && !redirect_valid_i) begin
               w = mem_word(m_req);
               exp_q.push_back('{pc: m_req, inst: m_req[2] ? w[63:32] : w[31:0]});
            end
         end else if (redirect_valid_i) begin
            m_cancel = 1'b1;
         end
         if (redirect_valid_i) begin
            exp_q.delete();
            m_pc = {redirect_pc_i[63:2], 2'b00};
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_req(input logic lvl, input int budget, input string name);
      int n = 0;
      while (if_addr_valid_o !== lvl && n < budget) begin
         tick();
         n++;
      end
      check(name, if_addr_valid_o, lvl);
   endtask

   task automatic wait_inst(input int budget, input string name);
      int n = 0;
      while (inst_valid_o !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(name, inst_valid_o, 1'b1);
   endtask

   task automatic redirect(input logic [63:0] target);
      redirect_valid_i = 1'b1;
      redirect_pc_i = target;
      tick();
      redirect_valid_i = 1'b0;
   endtask

   initial begin
      logic [63:0] w;
      int n;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;

      // Reset fetch, then fill the FIFO under backpressure.
      force_delay = 3;
      wait_inst(30, "boot_inst_timeout");
      check("boot_pc", inst_pc_o, 64'h0000_0000_8000_0000);
      check("boot_inst", inst_o, 32'h0010_0093);
      repeat (20) tick();
      check("bp_no_third_req", if_addr_valid_o, 1'b0);
      check("bp_head_held", inst_valid_o, 1'b1);
      inst_ready_i = 1'b1;
      tick();
      inst_ready_i = 1'b0;
      check("bp_second_pc", inst_pc_o, 64'h0000_0000_8000_0004);
      check("bp_second_inst", inst_o, 32'h0000_0013);
      wait_req(1'b1, 3, "bp_refill_req");
      inst_ready_i = 1'b1;

      // Redirect while a read is outstanding: the response is dropped.
      wait_req(1'b0, 20, "rw_idle");
      wait_req(1'b1, 20, "rw_req");
      redirect(64'h0000_0000_8000_0100);
      check("rw_inst_valid", inst_valid_o, 1'b0);
      wait_req(1'b0, 20, "rw_drop_done");
      wait_req(1'b1, 5, "rw_new_req");
      check("rw_new_addr", if_rd_addr_o, 64'h0000_0000_8000_0100);

      // Redirect in the same cycle as the response.
      force_delay = 2;
      wait_req(1'b0, 20, "co_idle");
      wait_req(1'b1, 20, "co_req");
      n = 0;
      while (if_data_valid_i !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("co_resp_seen", if_data_valid_i, 1'b1);
      redirect(64'h0000_0000_8000_0200);
      check("co_no_push", inst_valid_o, 1'b0);
      wait_req(1'b1, 5, "co_new_req");
      check("co_new_addr", if_rd_addr_o, 64'h0000_0000_8000_0200);

      // Two redirects while one read is being dropped; the second selects the upper word.
      force_delay = 5;
      wait_req(1'b0, 20, "dd_idle");
      wait_req(1'b1, 20, "dd_req");
      redirect(64'h0000_0000_0000_0100);
      tick();
      redirect(64'h0000_0000_0000_0204);
      wait_req(1'b0, 20, "dd_drop_done");
      wait_req(1'b1, 5, "dd_new_req");
      check("dd_new_addr", if_rd_addr_o, 64'h0000_0000_0000_0200);
      wait_inst(20, "dd_inst_timeout");
      w = mem_word(64'h200);
      check("dd_pc", inst_pc_o, 64'h0000_0000_0000_0204);
      check("dd_inst", inst_o, w[63:32]);

      // Random backpressure, redirects (including PC wrap) and spurious responses.
      force_delay = -1;
      spurious_en = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         inst_ready_i = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 24) == 0) begin
            case ($urandom_range(0, 3))
               0: redirect_pc_i = {$urandom, $urandom};
               1: redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
               2: redirect_pc_i = RESET_PC;
               default: redirect_pc_i = {32'd0, $urandom};
            endcase
            redirect_valid_i = 1'b1;
         end else begin
            redirect_valid_i = 1'b0;
         end
         tick();
      end
      redirect_valid_i = 1'b0;
      spurious_en = 1'b0;
      check("rand_progress", pops > 100, 1'b1);

      // Asynchronous reset in the middle of a read.
      inst_ready_i = 1'b1;
      force_delay = 4;
      wait_req(1'b0, 20, "ar_idle");
      wait_req(1'b1, 20, "ar_req");
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("ar_valid_drop", if_addr_valid_o, 1'b0);
      check("ar_inst_valid", inst_valid_o, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      wait_req(1'b1, 3, "ar_restart_req");
      check("ar_restart_addr", if_rd_addr_o, RESET_PC);
      repeat (30) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
